axil_bram_bridge: RTL and testbench
===================================

AXIL_BRAM_BRIDGE -- requirements
Module: axil_bram_bridge

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the AXI data and BRAM data width; legal values are 32 and 64.
REQ-002 Parameter BASE_ADDR, default 32'h80000000, SHALL set the first byte address served.
REQ-003 Parameter DEPTH_WORDS, default 4096, SHALL set the memory size in DATA_W-bit words; it must be a power of two.
REQ-004 Parameter RD_LAT, default 2, SHALL set the BRAM read latency in cycles; legal range is 1..4.
REQ-005 Ports SHALL be, clock and reset first:
- clk  in  1  sole clock
- rstn  in  1  reset, asynchronous, active-low
- clka  out  1  equals clk
- rsta  out  1  equals !rstn
- ena  out  1  BRAM enable
- wea  out  DATA_W/8  byte write enables
- addra  out  32  byte offset from BASE_ADDR, word-aligned
- dina  out  DATA_W  write data
- douta  in  DATA_W  read data
- axi_ar{addr[32],valid,ready,prot[3]}  read address channel
- axi_r{data[DATA_W],resp[2],valid,ready}  read data channel
- axi_aw{addr[32],valid,ready,prot[3]}  write address channel
- axi_w{data[DATA_W],strb[DATA_W/8],valid,ready}  write data channel
- axi_b{resp[2],valid,ready}  write response channel

Function
REQ-006 The FSM SHALL have the states IDLE, RD_WAIT, RD_RESP, WR_ISSUE and WR_RESP; prot inputs are ignored.
REQ-007 AW and W SHALL be captured independently into holding registers; axi_awready (axi_wready) is high only while its holding register is empty and axi_bvalid is low.
REQ-008 A write pair SHALL be complete once both holding registers are full, in any arrival order, including both arriving in the same cycle.
REQ-009 In IDLE with a complete pair and axi_arvalid both present, the grant SHALL alternate via a priority bit that toggles on every grant; after reset the priority bit favours the read.
REQ-010 axi_arready SHALL equal (state==IDLE) && !(pair_complete && prio==WRITE), and SHALL NOT depend on axi_arvalid.
REQ-011 Read: the AR handshake at edge T SHALL drive addra and ena from edge T+1, capture douta after RD_LAT cycles, and raise axi_rvalid at edge T+1+RD_LAT.
REQ-012 axi_rdata and axi_rresp SHALL stay stable while axi_rvalid is high and axi_rready is low; the handshake returns the FSM to IDLE.
REQ-013 Write: a granted pair SHALL drive wea=wstrb, dina and addra for exactly one cycle (WR_ISSUE); axi_bvalid rises on the next edge.
REQ-014 The B handshake SHALL clear both holding registers and return the FSM to IDLE.
REQ-015 An address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*DATA_W/8) SHALL cause no BRAM write (wea=0) and no read wait, and SHALL return resp 2'b10 (SLVERR), with rdata 0 on reads.
REQ-016 Address low bits below the word size SHALL be masked to zero; the offset is computed modulo 2^32.
REQ-017 In-range responses SHALL use resp 2'b00.
REQ-018 Outside read and write access cycles, wea SHALL be 0 and ena may stay 1.

Reset
REQ-019 Asserting rstn low at any time, including mid-transaction, SHALL force state=IDLE, prio=READ, empty holding registers, addra=0, dina=0, wea=0, ena=1, axi_rdata=0, axi_rresp=0, axi_bresp=0, axi_rvalid=0 and axi_bvalid=0.
REQ-020 During reset, axi_arready, axi_awready and axi_wready SHALL all read 1; an in-flight transaction is dropped without a response.

Structure
REQ-021 A shared package SHALL hold the resp codes (OKAY=2'b00, SLVERR=2'b10) and the FSM state encoding.
REQ-022 The range check and offset computation SHALL be one combinational sub-module, bram_addr_check, instantiated once for AR and once for AW.

Verification
REQ-023 With RD_LAT=2: AR at 0x80000010, handshake at edge 0 -> addra=0x10 at edge 1, rvalid at edge 3, rdata=mem[4], rresp=00.
REQ-024 W (data 0xA5A5A5A5, strb 4'b0011) two cycles before AW at 0x80000008 -> a single wea=0011 pulse at addra=0x8; then bvalid, bresp=00; a readback returns only the low 16 bits changed.
REQ-025 A complete write pair and arvalid held together for four grants -> the grant order is read, write, read, write.
REQ-026 AR at 0x7FFFFFFC and AW at BASE+DEPTH bytes -> rresp=10, rdata=0, bresp=10, and wea is never nonzero.
REQ-027 rready held low for 5 cycles -> rdata stable throughout; rstn pulsed low during RD_WAIT -> all outputs at reset values immediately, with no rvalid afterwards.

Source files
------------

// File: rtl/axil_bram_bridge_pkg.sv
// Shared definitions for the AXI4-Lite to BRAM bridge: response codes,
// FSM state encoding, arbitration priority and address helpers.
package axil_bram_bridge_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_RD_RESP  = 3'd2,
    ST_WR_ISSUE = 3'd3,
    ST_WR_RESP  = 3'd4
  } state_t;

  typedef enum logic {
    PRIO_READ  = 1'b0,
    PRIO_WRITE = 1'b1
  } prio_t;

  // Clear the byte-lane bits below the word size (bytes is a power of two).
  function automatic logic [31:0] word_align(input logic [31:0] addr,
                                             input int unsigned bytes);
    logic [31:0] w_mask;
    w_mask = ~(32'(bytes) - 32'd1);
    return addr & w_mask;
  endfunction

endpackage

// File: rtl/axil_bram_bridge_addr_check.sv
// Combinational address decode: converts an AXI byte address into a
// word-aligned BRAM byte offset and flags whether it falls in the window.
module bram_addr_check
  import axil_bram_bridge_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic [31:0] i_addr,
  output logic [31:0] o_offset,
  output logic        o_in_range
);

  localparam int unsigned WORD_BYTES = DATA_W / 8;
  // Window size in bytes, one bit wider so a full 4 GiB window still compares.
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'(WORD_BYTES);

  logic [31:0] w_diff;

  // Offset wraps modulo 2^32, so addresses below the base land far above the span.
  always_comb begin
    w_diff     = i_addr - BASE_ADDR;
    o_offset   = word_align(w_diff, WORD_BYTES);
    o_in_range = ({1'b0, w_diff} < SPAN_BYTES);
  end

endmodule

// File: rtl/axil_bram_bridge.sv
// AXI4-Lite slave that serves a single-port BRAM. Reads and writes are
// serialised through one FSM; AW and W are buffered independently and
// contend with AR through an alternating priority bit.
module axil_bram_bridge
  import axil_bram_bridge_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned RD_LAT      = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  // BRAM port A
  output logic                  clka,
  output logic                  rsta,
  output logic                  ena,
  output logic [DATA_W/8-1:0]   wea,
  output logic [31:0]           addra,
  output logic [DATA_W-1:0]     dina,
  input  logic [DATA_W-1:0]     douta,
  // AXI read address
  input  logic [31:0]           axi_araddr,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  input  logic [2:0]            axi_arprot,
  // AXI read data
  output logic [DATA_W-1:0]     axi_rdata,
  output logic [1:0]            axi_rresp,
  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  // AXI write address
  input  logic [31:0]           axi_awaddr,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [2:0]            axi_awprot,
  // AXI write data
  input  logic [DATA_W-1:0]     axi_wdata,
  input  logic [DATA_W/8-1:0]   axi_wstrb,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  // AXI write response
  output logic [1:0]            axi_bresp,
  output logic                  axi_bvalid,
  input  logic                  axi_bready
);

  localparam int unsigned STRB_W     = DATA_W / 8;
  localparam logic [2:0]  RD_LAT_CNT = 3'(RD_LAT);

  // FSM and response registers
  state_t              r_state;
  prio_t               r_prio;
  logic [2:0]          r_rd_cnt;
  logic [31:0]         r_rd_off;
  logic                r_wr_err;
  logic [31:0]         r_addra;
  logic [DATA_W-1:0]   r_dina;
  logic [STRB_W-1:0]   r_wea;
  logic                r_ena;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_rresp;
  logic                r_rvalid;
  logic [1:0]          r_bresp;
  logic                r_bvalid;

  // Write holding registers
  logic                r_aw_full;
  logic [31:0]         r_aw_addr;
  logic                r_w_full;
  logic [DATA_W-1:0]   r_w_data;
  logic [STRB_W-1:0]   r_w_strb;

  // Decode and handshake wires
  logic [31:0]         w_ar_off;
  logic                w_ar_ok;
  logic [31:0]         w_aw_off;
  logic                w_aw_ok;
  logic                w_pair;
  logic                w_arready;
  logic                w_awready;
  logic                w_wready;
  logic                w_ar_hs;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_b_hs;
  logic                w_unused_prot;

  bram_addr_check #(
    .DATA_W      (DATA_W),
    .BASE_ADDR   (BASE_ADDR),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ar_check (
    .i_addr     (axi_araddr),
    .o_offset   (w_ar_off),
    .o_in_range (w_ar_ok)
  );

  bram_addr_check #(
    .DATA_W      (DATA_W),
    .BASE_ADDR   (BASE_ADDR),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_aw_check (
    .i_addr     (r_aw_addr),
    .o_offset   (w_aw_off),
    .o_in_range (w_aw_ok)
  );

  // Protection attributes carry no meaning for this memory.
  assign w_unused_prot = ^{axi_arprot, axi_awprot};

  assign w_pair    = r_aw_full && r_w_full;
  assign w_arready = (r_state == ST_IDLE) && !(w_pair && (r_prio == PRIO_WRITE));
  assign w_awready = !r_aw_full && !r_bvalid;
  assign w_wready  = !r_w_full && !r_bvalid;
  assign w_ar_hs   = axi_arvalid && w_arready;
  assign w_aw_hs   = axi_awvalid && w_awready;
  assign w_w_hs    = axi_wvalid && w_wready;
  assign w_b_hs    = r_bvalid && axi_bready;

  assign clka        = clk;
  assign rsta        = ~rstn;
  assign ena         = r_ena;
  assign wea         = r_wea;
  assign addra       = r_addra;
  assign dina        = r_dina;
  assign axi_arready = w_arready;
  assign axi_rdata   = r_rdata;
  assign axi_rresp   = r_rresp;
  assign axi_rvalid  = r_rvalid;
  assign axi_awready = w_awready;
  assign axi_wready  = w_wready;
  assign axi_bresp   = r_bresp;
  assign axi_bvalid  = r_bvalid;

  // Holding-register occupancy: filled by each handshake, emptied by the B handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
    end else if (w_b_hs) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
    end else begin
      if (w_aw_hs) r_aw_full <= 1'b1;
      if (w_w_hs)  r_w_full  <= 1'b1;
    end
  end

  // Holding-register payload, only meaningful while the matching full flag is set.
  always_ff @(posedge clk) begin
    if (w_aw_hs) r_aw_addr <= axi_awaddr;
    if (w_w_hs) begin
      r_w_data <= axi_wdata;
      r_w_strb <= axi_wstrb;
    end
  end

  // Transaction FSM: arbitration, BRAM drive and AXI response generation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_prio   <= PRIO_READ;
      r_rd_cnt <= 3'd0;
      r_rd_off <= 32'd0;
      r_wr_err <= 1'b0;
      r_addra  <= 32'd0;
      r_dina   <= '0;
      r_wea    <= '0;
      r_ena    <= 1'b1;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
      r_rvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
      r_bvalid <= 1'b0;
    end else begin
      r_ena <= 1'b1;
      r_wea <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_ar_hs) begin
            r_prio <= prio_t'(~r_prio);
            if (w_ar_ok) begin
              r_rd_off <= w_ar_off;
              r_rd_cnt <= 3'd0;
              r_state  <= ST_RD_WAIT;
            end else begin
              // Out-of-window read answers immediately without touching the BRAM.
              r_rdata  <= '0;
              r_rresp  <= RESP_SLVERR;
              r_rvalid <= 1'b1;
              r_state  <= ST_RD_RESP;
            end
          end else if (w_pair) begin
            r_prio   <= prio_t'(~r_prio);
            r_wr_err <= !w_aw_ok;
            if (w_aw_ok) begin
              r_wea   <= r_w_strb;
              r_dina  <= r_w_data;
              r_addra <= w_aw_off;
            end
            r_state <= ST_WR_ISSUE;
          end
        end
        ST_RD_WAIT: begin
          // Address goes out on the first wait cycle; data is taken RD_LAT cycles later.
          if (r_rd_cnt == 3'd0) r_addra <= r_rd_off;
          if (r_rd_cnt == RD_LAT_CNT) begin
            r_rdata  <= douta;
            r_rresp  <= RESP_OKAY;
            r_rvalid <= 1'b1;
            r_state  <= ST_RD_RESP;
          end else begin
            r_rd_cnt <= r_rd_cnt + 3'd1;
          end
        end
        ST_RD_RESP: begin
          if (axi_rready) begin
            r_rvalid <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        ST_WR_ISSUE: begin
          r_bresp  <= r_wr_err ? RESP_SLVERR : RESP_OKAY;
          r_bvalid <= 1'b1;
          r_state  <= ST_WR_RESP;
        end
        ST_WR_RESP: begin
          if (axi_bready) begin
            r_bvalid <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_bram_bridge.sv
// Directed bench for axil_bram_bridge with a BRAM model and
// queue-based scoreboards for R, B and BRAM write traffic.
module tb_axil_bram_bridge;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } wr_exp_t;

  logic        clk;
  logic        rstn;
  logic        clka, rsta, ena;
  logic [3:0]  wea;
  logic [31:0] addra, dina, douta;
  logic [31:0] axi_araddr;
  logic        axi_arvalid, axi_arready;
  logic [2:0]  axi_arprot, axi_awprot;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid, axi_rready;
  logic [31:0] axi_awaddr;
  logic        axi_awvalid, axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid, axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid, axi_bready;

  int n_checks = 0;
  int n_fail   = 0;

  r_exp_t  r_q[$];
  logic [1:0] b_q[$];
  wr_exp_t wr_q[$];
  bit      log_q[$];
  r_exp_t  r_pop;
  wr_exp_t wr_pop;
  logic [1:0] b_pop;

  logic [31:0] mem [0:4095];
  bit mem_init = 1'b0;

  axil_bram_bridge #(
    .DATA_W(32), .BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(4096), .RD_LAT(2)
  ) dut (
    .clk(clk), .rstn(rstn),
    .clka(clka), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra),
    .dina(dina), .douta(douta),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_arprot(axi_arprot),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_awprot(axi_awprot),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: one output register, so douta follows addra by one edge.
  always @(posedge clka) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'hDEAD_0000 | 32'(i);
      mem_init <= 1'b1;
    end else if (ena) begin
      douta <= mem[addra[13:2]];
      for (int b = 0; b < 4; b++)
        if (wea[b]) mem[addra[13:2]][8*b +: 8] <= dina[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    if (rstn && axi_rvalid && axi_rready) begin
      log_q.push_back(1'b0);
      chk("r_expected", 64'(r_q.size() != 0), 64'd1);
      if (r_q.size() != 0) begin
        r_pop = r_q.pop_front();
        chk("rdata", 64'(axi_rdata), 64'(r_pop.data));
        chk("rresp", 64'(axi_rresp), 64'(r_pop.resp));
      end
    end
    if (rstn && axi_bvalid && axi_bready) begin
      log_q.push_back(1'b1);
      chk("b_expected", 64'(b_q.size() != 0), 64'd1);
      if (b_q.size() != 0) begin
        b_pop = b_q.pop_front();
        chk("bresp", 64'(axi_bresp), 64'(b_pop));
      end
    end
    if (rstn && wea != 4'd0) begin
      chk("bram_wr_expected", 64'(wr_q.size() != 0), 64'd1);
      if (wr_q.size() != 0) begin
        wr_pop = wr_q.pop_front();
        chk("bram_wr_addr", 64'(addra), 64'(wr_pop.addr));
        chk("bram_wr_strb", 64'(wea), 64'(wr_pop.strb));
        chk("bram_wr_data", 64'(dina), 64'(wr_pop.data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic ar_send(input logic [31:0] a);
    bit got = 1'b0;
    bit rdy;
    axi_araddr = a;
    axi_arvalid = 1'b1;
    for (int i = 0; i < 64 && !got; i++) begin
      rdy = axi_arready;
      step();
      got = rdy;
    end
    axi_arvalid = 1'b0;
    chk("ar_handshake", 64'(got), 64'd1);
  endtask

  task automatic aw_send(input logic [31:0] a);
    bit got = 1'b0;
    bit rdy;
    axi_awaddr = a;
    axi_awvalid = 1'b1;
    for (int i = 0; i < 64 && !got; i++) begin
      rdy = axi_awready;
      step();
      got = rdy;
    end
    axi_awvalid = 1'b0;
    chk("aw_handshake", 64'(got), 64'd1);
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s);
    bit got = 1'b0;
    bit rdy;
    axi_wdata = d;
    axi_wstrb = s;
    axi_wvalid = 1'b1;
    for (int i = 0; i < 64 && !got; i++) begin
      rdy = axi_wready;
      step();
      got = rdy;
    end
    axi_wvalid = 1'b0;
    chk("w_handshake", 64'(got), 64'd1);
  endtask

  task automatic wait_drain(input string nm);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (r_q.size() == 0 && b_q.size() == 0 && wr_q.size() == 0 &&
          !axi_rvalid && !axi_bvalid) done = 1'b1;
      else step();
    end
    chk(nm, 64'(done), 64'd1);
  endtask

  task automatic chk_reset();
    chk("rst_addra", 64'(addra), 64'd0);
    chk("rst_dina", 64'(dina), 64'd0);
    chk("rst_wea", 64'(wea), 64'd0);
    chk("rst_ena", 64'(ena), 64'd1);
    chk("rst_rdata", 64'(axi_rdata), 64'd0);
    chk("rst_rresp", 64'(axi_rresp), 64'd0);
    chk("rst_bresp", 64'(axi_bresp), 64'd0);
    chk("rst_rvalid", 64'(axi_rvalid), 64'd0);
    chk("rst_bvalid", 64'(axi_bvalid), 64'd0);
    chk("rst_arready", 64'(axi_arready), 64'd1);
    chk("rst_awready", 64'(axi_awready), 64'd1);
    chk("rst_wready", 64'(axi_wready), 64'd1);
    chk("rst_rsta", 64'(rsta), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nar, naw, nw;
    bit h_ar, h_aw, h_w, done;
    rstn = 1'b1;
    axi_araddr = '0; axi_arvalid = 1'b0; axi_arprot = 3'd0;
    axi_awaddr = '0; axi_awvalid = 1'b0; axi_awprot = 3'd0;
    axi_wdata = '0;  axi_wstrb = '0;     axi_wvalid = 1'b0;
    axi_rready = 1'b1; axi_bready = 1'b1;
    #1 rstn = 1'b0;
    #2 chk_reset();
    repeat (3) step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    chk("rsta_released", 64'(rsta), 64'd0);

    // Aligned read: addra one edge after AR, rvalid RD_LAT edges after that.
    r_q.push_back('{data: 32'hDEAD_0004, resp: 2'b00});
    ar_send(32'h8000_0010);
    chk("addra_at_T0", 64'(addra), 64'd0);
    chk("rvalid_at_T0", 64'(axi_rvalid), 64'd0);
    step();
    chk("addra_at_T1", 64'(addra), 64'h10);
    chk("ena_at_T1", 64'(ena), 64'd1);
    chk("rvalid_at_T1", 64'(axi_rvalid), 64'd0);
    step();
    chk("rvalid_at_T2", 64'(axi_rvalid), 64'd0);
    step();
    chk("rvalid_at_T3", 64'(axi_rvalid), 64'd1);
    wait_drain("drain_read_aligned");

    // Unaligned read: low address bits are dropped.
    r_q.push_back('{data: 32'hDEAD_0005, resp: 2'b00});
    ar_send(32'h8000_0017);
    step();
    chk("addra_masked", 64'(addra), 64'h14);
    wait_drain("drain_read_masked");

    // W two cycles ahead of AW, partial strobe.
    wr_q.push_back('{addr: 32'h8, strb: 4'b0011, data: 32'hA5A5_A5A5});
    b_q.push_back(2'b00);
    w_send(32'hA5A5_A5A5, 4'b0011);
    step();
    step();
    aw_send(32'h8000_0008);
    step();
    chk("wea_issue", 64'(wea), 64'h3);
    chk("addra_issue", 64'(addra), 64'h8);
    step();
    chk("wea_after_issue", 64'(wea), 64'd0);
    chk("bvalid_after_issue", 64'(axi_bvalid), 64'd1);
    wait_drain("drain_write_partial");
    r_q.push_back('{data: 32'hDEAD_A5A5, resp: 2'b00});
    ar_send(32'h8000_0008);
    wait_drain("drain_readback");

    // Out-of-window read (below base) and write (one past the end).
    r_q.push_back('{data: 32'h0, resp: 2'b10});
    ar_send(32'h7FFF_FFFC);
    chk("rvalid_no_wait", 64'(axi_rvalid), 64'd1);
    wait_drain("drain_read_err");
    b_q.push_back(2'b10);
    fork
      aw_send(32'h8000_4000);
      w_send(32'hFFFF_FFFF, 4'hF);
    join
    wait_drain("drain_write_err");

    // Read data held while rready is low.
    axi_rready = 1'b0;
    r_q.push_back('{data: 32'hDEAD_0001, resp: 2'b00});
    ar_send(32'h8000_0004);
    for (int i = 0; i < 20 && !axi_rvalid; i++) step();
    chk("rvalid_stall_rise", 64'(axi_rvalid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("rdata_stall", 64'(axi_rdata), 64'hDEAD_0001);
      chk("rvalid_stall", 64'(axi_rvalid), 64'd1);
      step();
    end
    axi_rready = 1'b1;
    wait_drain("drain_stall");

    // Reset pulse while waiting on the BRAM: read is dropped.
    ar_send(32'h8000_0010);
    step();
    rstn = 1'b0;
    #1 chk_reset();
    step();
    step();
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("no_rvalid_after_reset", 64'(axi_rvalid), 64'd0);
    end

    // Contention: pair and AR held together alternate grants.
    log_q.delete();
    for (int i = 0; i < 2; i++) begin
      r_q.push_back('{data: 32'hDEAD_000C, resp: 2'b00});
      b_q.push_back(2'b00);
      wr_q.push_back('{addr: 32'h20, strb: 4'hF, data: 32'h1111_1111});
    end
    nar = 0; naw = 0; nw = 0; done = 1'b0;
    axi_araddr = 32'h8000_0030; axi_arvalid = 1'b1;
    axi_awaddr = 32'h8000_0020; axi_awvalid = 1'b1;
    axi_wdata = 32'h1111_1111; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      h_ar = axi_arvalid && axi_arready;
      h_aw = axi_awvalid && axi_awready;
      h_w  = axi_wvalid && axi_wready;
      step();
      if (h_ar) nar++;
      if (h_aw) naw++;
      if (h_w)  nw++;
      if (nar == 2) axi_arvalid = 1'b0;
      if (naw == 2) axi_awvalid = 1'b0;
      if (nw == 2)  axi_wvalid = 1'b0;
      done = (nar == 2) && (naw == 2) && (nw == 2);
    end
    axi_arvalid = 1'b0; axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    chk("contention_handshakes", 64'(done), 64'd1);
    wait_drain("drain_contention");
    chk("grant_count", 64'(log_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < log_q.size()) chk($sformatf("grant_order_%0d", i), 64'(log_q[i]), 64'(i % 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
